// File: rtl/fifo_pop_ctrl_pkg.sv
// Shared definitions for the FIFO read-side controller: widths, FSM encoding
// and the skid-occupancy helper used by the read scheduler.
package fifo_pop_ctrl_pkg;

    localparam int DATA_SIZE_DEF = 10;
    localparam int CNT_SIZE_DEF  = 16;
    localparam int SKID_DEPTH    = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BURST   = 2'd1,
        ST_TRICKLE = 2'd2,
        ST_GAP     = 2'd3
    } pop_state_e;

    // Room for one more read: occupancy after this edge, counting the word already
    // in flight and crediting the head word leaving downstream, must stay below depth.
    function automatic logic skid_has_space(input logic [1:0] skid_cnt,
                                            input logic       inflight,
                                            input logic       leaving);
        logic [2:0] occ;
        occ = {1'b0, skid_cnt} + {2'b00, inflight} - {2'b00, leaving};
        return occ < 3'(SKID_DEPTH);
    endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry registered skid buffer; slot0 is the head and drives downstream directly.
// Push and pop in the same cycle are both honoured.
module fifo_skid_buf
    import fifo_pop_ctrl_pkg::*;
#(
    parameter int DATA_SIZE = DATA_SIZE_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic [DATA_SIZE-1:0] push_data,
    input  logic                 pop,
    output logic [DATA_SIZE-1:0] head_data,
    output logic                 head_vld,
    output logic [1:0]           count
);

    logic [DATA_SIZE-1:0] slot0_data;
    logic [DATA_SIZE-1:0] slot1_data;
    logic                 slot0_vld;
    logic                 slot1_vld;
    logic                 pop_ok;

    assign pop_ok = pop && slot0_vld;

    always_ff @(posedge clk) begin
        if (reset) begin
            slot0_vld  <= 1'b0;
            slot1_vld  <= 1'b0;
            slot0_data <= '0;
        end else begin
            case ({push, pop_ok})
                2'b11: begin
                    // Occupancy unchanged; slot1 (if any) advances, new word fills behind it
                    if (slot1_vld) begin
                        slot0_data <= slot1_data;
                    end else begin
                        slot0_data <= push_data;
                    end
                end
                2'b01: begin
                    if (slot1_vld) begin
                        slot0_data <= slot1_data;
                    end
                    slot0_vld <= slot1_vld;
                    slot1_vld <= 1'b0;
                end
                2'b10: begin
                    if (!slot0_vld) begin
                        slot0_data <= push_data;
                        slot0_vld  <= 1'b1;
                    end else begin
                        slot1_vld  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && slot0_vld && (!pop_ok || slot1_vld)) begin
            slot1_data <= push_data;
        end
    end

    assign head_data = slot0_data;
    assign head_vld  = slot0_vld;
    assign count     = {1'b0, slot0_vld} + {1'b0, slot1_vld};

endmodule

// File: rtl/fifo_pop_ctrl.sv
// Read-side controller for the switch data FIFO: schedules pops, absorbs the
// one-cycle FIFO read latency in a skid buffer and forwards words with valid/pause.
module fifo_pop_ctrl
    import fifo_pop_ctrl_pkg::*;
#(
    parameter int DATA_SIZE = DATA_SIZE_DEF,
    parameter int CNT_SIZE  = CNT_SIZE_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fifo_empty,
    input  logic                 almost_empty,
    input  logic                 fifo_error,
    input  logic [DATA_SIZE-1:0] data_out_pop,
    output logic                 read,
    input  logic                 dest_pause,
    output logic [DATA_SIZE-1:0] data_out,
    output logic                 valid_out,
    output logic [CNT_SIZE-1:0]  words_fwd,
    output logic                 pop_error
);

    pop_state_e state;
    pop_state_e state_nxt;
    logic       read_nxt;
    logic       inflight_p1;
    logic       accept;
    logic       space;
    logic [1:0] skid_cnt;

    assign accept = valid_out && !dest_pause;
    assign space  = skid_has_space(skid_cnt, inflight_p1, accept);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        read_nxt  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty && space) begin
                    state_nxt = almost_empty ? ST_TRICKLE : ST_BURST;
                end
            end
            ST_BURST: begin
                if (fifo_empty || !space) begin
                    state_nxt = ST_IDLE;
                end else if (almost_empty) begin
                    state_nxt = ST_TRICKLE;
                end else begin
                    read_nxt = 1'b1;
                end
            end
            ST_TRICKLE: begin
                if (fifo_empty) begin
                    state_nxt = ST_IDLE;
                end else if (space) begin
                    read_nxt  = 1'b1;
                    state_nxt = ST_GAP;
                end
            end
            ST_GAP: begin
                // Quiet cycle so the FIFO flags reflect the last pop before re-arming
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign read = read_nxt;

    // Stage p1: FIFO return word valid, marked by inflight_p1
    always_ff @(posedge clk) begin
        if (reset) begin
            inflight_p1 <= 1'b0;
        end else begin
            inflight_p1 <= read;
        end
    end

    // Stage p2: skid buffer head is the downstream output register
    fifo_skid_buf #(
        .DATA_SIZE (DATA_SIZE)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .push      (inflight_p1),
        .push_data (data_out_pop),
        .pop       (accept),
        .head_data (data_out),
        .head_vld  (valid_out),
        .count     (skid_cnt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            words_fwd <= '0;
            pop_error <= 1'b0;
        end else begin
            words_fwd <= words_fwd + {{(CNT_SIZE-1){1'b0}}, accept};
            if (fifo_error && inflight_p1) begin
                pop_error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_pop_ctrl.sv
// Directed bench for fifo_pop_ctrl with a behavioural FIFO model and an in-order scoreboard.
module tb_fifo_pop_ctrl;

    localparam int DW = 10;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          dest_pause = 1'b0;
    logic          force_err = 1'b0;
    logic          mon_clr = 1'b0;
    logic          err_q = 1'b0;
    logic          fifo_empty;
    logic          almost_empty;
    logic          fifo_error;
    logic          read;
    logic          valid_out;
    logic          pop_error;
    logic [DW-1:0] data_out_pop = '0;
    logic [DW-1:0] data_out;
    logic [CW-1:0] words_fwd;

    logic [DW-1:0] src[$];
    int head = 0;
    int tail = 0;
    int fifo_cnt;

    int n_cmp = 0;
    int n_err = 0;

    int cyc = 0;
    int n_read = 0;
    int n_xfer = 0;
    int run = 0;
    int max_run = 0;
    int first_rd = -1;
    int first_vld = -1;
    int inv_err = 0;
    int seq_err = 0;
    int exp_idx = 0;

    always #5 clk = ~clk;

    assign fifo_cnt     = tail - head;
    assign fifo_empty   = (fifo_cnt == 0);
    assign almost_empty = (fifo_cnt <= 1);
    assign fifo_error   = err_q | force_err;

    fifo_pop_ctrl #(
        .DATA_SIZE (DW),
        .CNT_SIZE  (CW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .fifo_empty   (fifo_empty),
        .almost_empty (almost_empty),
        .fifo_error   (fifo_error),
        .data_out_pop (data_out_pop),
        .read         (read),
        .dest_pause   (dest_pause),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .words_fwd    (words_fwd),
        .pop_error    (pop_error)
    );

    // FIFO model: one-cycle read latency, error on read while empty
    always @(posedge clk) begin
        err_q <= read && fifo_empty;
        if (read && !fifo_empty) begin
            data_out_pop <= src[head];
            head <= head + 1;
        end
    end

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (mon_clr) begin
            n_read    <= 0;
            n_xfer    <= 0;
            run       <= 0;
            max_run   <= 0;
            first_rd  <= -1;
            first_vld <= -1;
        end else if (!reset) begin
            if (read) begin
                n_read <= n_read + 1;
                run    <= run + 1;
                if (run + 1 > max_run) max_run <= run + 1;
                if (first_rd < 0) first_rd <= cyc;
                if (fifo_empty) inv_err <= inv_err + 1;
            end else begin
                run <= 0;
            end
            if (valid_out && first_vld < 0) first_vld <= cyc;
            if (valid_out && !dest_pause) begin
                n_xfer  <= n_xfer + 1;
                exp_idx <= exp_idx + 1;
                if (exp_idx >= src.size() || data_out !== src[exp_idx]) seq_err <= seq_err + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic load(input logic [DW-1:0] w);
        src.push_back(w);
        tail++;
    endtask

    task automatic clr_mon();
        @(posedge clk); #1 mon_clr = 1'b1;
        @(posedge clk); #1 mon_clr = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int quiet = 0;
        int i = 0;
        while (quiet < 4 && i < limit) begin
            @(negedge clk);
            i++;
            if (fifo_cnt == 0 && !valid_out && !read) quiet++;
            else quiet = 0;
        end
        if (quiet < 4) chk("drain_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int i;
        logic [DW-1:0] held;

        // Reset held two cycles with words waiting in the FIFO
        for (int k = 1; k <= 8; k++) load(DW'(k));
        repeat (2) begin
            @(negedge clk);
            chk("rst_read", read, 0);
            chk("rst_valid", valid_out, 0);
            chk("rst_fwd", words_fwd, 0);
            chk("rst_perr", pop_error, 0);
        end
        @(posedge clk); #1 reset = 1'b0;

        // Burst drain of 8 words
        wait_idle(200);
        chk("burst_reads", n_read, 8);
        chk("burst_run", max_run, 7);
        chk("burst_xfer", n_xfer, 8);
        chk("burst_lat", first_vld - first_rd, 2);
        chk("burst_fwd", words_fwd, 8);
        chk("burst_order", seq_err, 0);

        // Backpressure mid-burst
        clr_mon();
        for (int k = 1; k <= 10; k++) load(DW'(10'h100 + k));
        i = 0;
        while (n_xfer < 3 && i < 100) begin
            @(negedge clk);
            i++;
        end
        chk("bp_start", n_xfer >= 3, 1);
        @(posedge clk); #1 dest_pause = 1'b1;
        @(negedge clk);
        held = data_out;
        chk("bp_vld", valid_out, 1);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk("bp_hold", data_out, held);
            chk("bp_hold_vld", valid_out, 1);
            chk("bp_rd", read, 0);
            chk("bp_occ", (n_read - n_xfer) <= 2, 1);
        end
        @(posedge clk); #1 dest_pause = 1'b0;
        wait_idle(200);
        chk("bp_reads", n_read, 10);
        chk("bp_xfer", n_xfer, 10);
        chk("bp_fwd", words_fwd, 18);
        chk("bp_order", seq_err, 0);

        // Single word with almost_empty already high
        clr_mon();
        load(10'h2A5);
        wait_idle(100);
        chk("one_reads", n_read, 1);
        chk("one_xfer", n_xfer, 1);
        chk("one_fwd", words_fwd, 19);
        chk("one_perr", pop_error, 0);
        chk("one_order", seq_err, 0);

        // Error flag the cycle after a read
        clr_mon();
        load(10'h155);
        i = 0;
        while (!read && i < 20) begin
            @(negedge clk);
            i++;
        end
        chk("err_rd_seen", read, 1);
        @(posedge clk); #1 force_err = 1'b1;
        @(posedge clk); #1 force_err = 1'b0;
        wait_idle(100);
        chk("err_set", pop_error, 1);
        repeat (10) @(negedge clk);
        chk("err_sticky", pop_error, 1);
        chk("err_fwd", words_fwd, 20);
        @(posedge clk); #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("err_clr", pop_error, 0);
        chk("rst2_fwd", words_fwd, 0);
        @(posedge clk); #1 force_err = 1'b1;
        repeat (2) @(posedge clk);
        #1 force_err = 1'b0;
        @(negedge clk);
        chk("err_noread", pop_error, 0);

        // Counter wrap: 65535 words, then two more across the boundary
        clr_mon();
        for (int k = 0; k < 65535; k++) load(DW'(k + 32'h200));
        wait_idle(70000);
        chk("wrap_pre", words_fwd, 16'hFFFF);
        chk("wrap_xfer", n_xfer, 65535);
        chk("wrap_order", seq_err, 0);
        @(posedge clk); #1 dest_pause = 1'b1;
        load(10'h3C3);
        load(10'h03C);
        repeat (10) @(negedge clk);
        chk("wrap_hold_vld", valid_out, 1);
        chk("wrap_hold_data", data_out, 10'h3C3);
        @(posedge clk); #1 dest_pause = 1'b0;
        @(negedge clk);
        chk("wrap_ffff", words_fwd, 16'hFFFF);
        @(negedge clk);
        chk("wrap_0000", words_fwd, 16'h0000);
        chk("wrap_d2", data_out, 10'h03C);
        @(negedge clk);
        chk("wrap_0001", words_fwd, 16'h0001);
        chk("wrap_empty", valid_out, 0);
        repeat (2) @(negedge clk);
        chk("final_order", seq_err, 0);
        chk("never_rd_empty", inv_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
